// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter and sequencer for the single-ported
//   DataMemory. Port 0 is the CPU load/store stage, port 1 is the
//   debug/loader port. One access is in flight at a time, walking through
//   IDLE -> ISSUE -> RESP, so throughput is one access per three cycles.
//
//   Ports
//     clock, reset          rising-edge clock, synchronous active-high reset
//     rN_req/we/addr/wdata  request N (held until rN_gnt), 1 = write
//     rN_gnt                request N accepted (1-cycle pulse)
//     rN_rvalid/rN_rdata    read data for N (pulse / held until next read)
//     mem_addr/read/write/wdata/rdata  DataMemory interface
//     busy                  high while the FSM is not IDLE
//
//   Optional feature (macro DMEM_ARB_PERF_EN)
//     Adds parameter CNT_W and the saturating counters perf_gnt0,
//     perf_gnt1 (grants per port) and perf_conflict (IDLE cycles with
//     both requests high).

module dmem_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_gnt0,
    output logic [CNT_W-1:0]  perf_gnt1,
    output logic [CNT_W-1:0]  perf_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    logic   lastGrant;   // port granted most recently
    logic   curPort;     // port owning the access in flight
    logic   curWe;       // access in flight is a write

    logic              anyReq;
    logic              bothReq;
    logic              winner;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // With a single request that port wins; on a conflict the port that
    // did not win last time goes next.
    always_comb begin
        anyReq   = r0_req | r1_req;
        bothReq  = r0_req & r1_req;
        winner   = bothReq ? ~lastGrant : r1_req;
        selWe    = winner ? r1_we    : r0_we;
        selAddr  = winner ? r1_addr  : r0_addr;
        selWdata = winner ? r1_wdata : r0_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            curPort   <= 1'b0;
            curWe     <= 1'b0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        curPort   <= winner;
                        curWe     <= selWe;
                        lastGrant <= winner;
                        mem_addr  <= selAddr;
                        mem_wdata <= selWdata;
                        mem_write <= selWe;
                        mem_read  <= ~selWe;
                        r0_gnt    <= ~winner;
                        r1_gnt    <= winner;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobes were stable for this whole cycle; the memory
                    // commits a write and presents read data at this edge.
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    r0_gnt    <= 1'b0;
                    r1_gnt    <= 1'b0;
                    if (!curWe) begin
                        if (curPort) begin
                            r1_rdata  <= mem_rdata;
                            r1_rvalid <= 1'b1;
                        end else begin
                            r0_rdata  <= mem_rdata;
                            r0_rvalid <= 1'b1;
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    r0_rvalid <= 1'b0;
                    r1_rvalid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Counters advance on the same edge as the grant they count and stick
    // at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else if (state == IDLE) begin
            if (anyReq && !winner && perf_gnt0 != '1)
                perf_gnt0 <= perf_gnt0 + CNT_W'(1);
            if (anyReq && winner && perf_gnt1 != '1)
                perf_gnt1 <= perf_gnt1 + CNT_W'(1);
            if (bothReq && perf_conflict != '1)
                perf_conflict <= perf_conflict + CNT_W'(1);
        end
    end
`endif

endmodule
